// File: rtl/dds_wave_gen.sv
// -----------------------------------------------------------------------------
// dds_wave_gen
//
// Multi-waveform direct digital synthesis generator. A phase accumulator
// (advanced by the frequency tuning word) plus a phase offset forms a phase
// code that drives an external synchronous sine ROM or the built-in square,
// triangle and sawtooth generators. The selected sample is scaled about
// midscale by an amplitude gain of (amp+1)/2^AMP_W.
//
// Configuration arrives through a valid/ready handshake into a shadow
// register. It is applied at the next accumulator wrap, so frequency changes
// are phase-continuous. It is applied on the following edge instead when the
// generator is stopped, idle (freq 0) or being cleared.
//
// Optional feature, enabled by defining DDS_SWEEP_EN:
//   adds sweep_step / sweep_stop inputs for a sawtooth frequency chirp that
//   is advanced at every wrap.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   en                      accumulator advances when 1
//   acc_clr                 synchronous accumulator clear (forces pending apply)
//   cfg_valid / cfg_ready   configuration handshake
//   cfg_freq/phase/wave/amp configuration words
//   sweep_step, sweep_stop  chirp increment and limit (DDS_SWEEP_EN only)
//   rom_addr / rom_data     sine ROM interface (data one clock after address)
//   wave_out, wave_valid    registered sample and its enable tag
//   sync_out                one-cycle pulse after each accumulator wrap
// -----------------------------------------------------------------------------
module dds_wave_gen #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 11,
    parameter int DATA_W  = 10,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               acc_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_freq,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [1:0]         cfg_wave,
    input  logic [AMP_W-1:0]   cfg_amp,
`ifdef DDS_SWEEP_EN
    input  logic [ACC_W-1:0]   sweep_step,
    input  logic [ACC_W-1:0]   sweep_stop,
`endif
    output logic [PHASE_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               sync_out
);

    localparam int                PROD_W = DATA_W + AMP_W + 3;
    localparam logic [DATA_W-1:0] MID    = DATA_W'(1) << (DATA_W - 1);

    // ------------------------------------------------------------------
    // Accumulator and active / shadow configuration
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   freq_q, freq_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         mode_q, mode_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic               pending_q, pending_d;
    logic               clr_seen_q;
    logic [ACC_W-1:0]   sh_freq_q;
    logic [PHASE_W-1:0] sh_phase_q;
    logic [1:0]         sh_mode_q;
    logic [AMP_W-1:0]   sh_amp_q;
    logic               sync_q;

    logic [ACC_W:0]     acc_sum;
    logic               wrap;
    logic               cfg_accept;
    logic               cfg_apply;
    logic [PHASE_W-1:0] phase_code;

`ifdef DDS_SWEEP_EN
    logic [ACC_W-1:0]   base_freq_q, base_freq_d;
    logic [ACC_W:0]     sweep_sum;
`endif

    assign acc_sum    = {1'b0, acc_q} + {1'b0, freq_q};
    assign wrap       = en & ~acc_clr & acc_sum[ACC_W];
    assign cfg_ready  = ~pending_q;
    assign cfg_accept = cfg_valid & ~pending_q;
    // A pending config normally waits for the wrap; when the accumulator
    // is stopped, idle or being cleared no wrap would come, so apply now.
    // clr_seen_q remembers an acc_clr seen during the acceptance cycle.
    assign cfg_apply  = pending_q & (wrap | ~en | (freq_q == '0) | acc_clr | clr_seen_q);
    assign phase_code = acc_q[ACC_W-1 -: PHASE_W] + phase_q;

    always_comb begin
        if (acc_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_sum[ACC_W-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    always_comb begin
        freq_d    = freq_q;
        phase_d   = phase_q;
        mode_d    = mode_q;
        amp_d     = amp_q;
        pending_d = pending_q;
`ifdef DDS_SWEEP_EN
        base_freq_d = base_freq_q;
        sweep_sum   = {1'b0, freq_q} + {1'b0, sweep_step};
`endif
        if (cfg_apply) begin
            freq_d    = sh_freq_q;
            phase_d   = sh_phase_q;
            mode_d    = sh_mode_q;
            amp_d     = sh_amp_q;
            pending_d = 1'b0;
`ifdef DDS_SWEEP_EN
            base_freq_d = sh_freq_q;
`endif
        end
`ifdef DDS_SWEEP_EN
        // Chirp: step the frequency at each wrap, falling back to the
        // last configured frequency once the stop value is reached.
        else if (wrap && (sweep_step != '0)) begin
            if (sweep_sum >= {1'b0, sweep_stop}) begin
                freq_d = base_freq_q;
            end else begin
                freq_d = sweep_sum[ACC_W-1:0];
            end
        end
`else
        // Without the sweep the frequency only changes through config.
`endif
        if (cfg_accept) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            freq_q     <= '0;
            phase_q    <= '0;
            mode_q     <= 2'd0;
            amp_q      <= '1;
            pending_q  <= 1'b0;
            clr_seen_q <= 1'b0;
            sh_freq_q  <= '0;
            sh_phase_q <= '0;
            sh_mode_q  <= 2'd0;
            sh_amp_q   <= '1;
            sync_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            freq_q    <= freq_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            amp_q     <= amp_d;
            pending_q <= pending_d;
            sync_q    <= wrap;
            if (cfg_accept) begin
                sh_freq_q  <= cfg_freq;
                sh_phase_q <= cfg_phase;
                sh_mode_q  <= cfg_wave;
                sh_amp_q   <= cfg_amp;
                clr_seen_q <= acc_clr;
            end else if (cfg_apply) begin
                clr_seen_q <= 1'b0;
            end
        end
    end

`ifdef DDS_SWEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_freq_q <= '0;
        end else begin
            base_freq_q <= base_freq_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sample pipeline: phase code -> ROM address -> ROM data -> output.
    // Mode and amplitude travel with each phase code so a config change
    // never mixes settings within one sample.
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] rom_addr_q;
    logic [1:0]         mode1_q, mode2_q;
    logic [AMP_W-1:0]   amp1_q, amp2_q;
    logic               vld1_q, vld2_q;
    logic [PHASE_W-1:0] p2_q;
    logic [DATA_W-1:0]  wave_out_q, wave_out_d;
    logic               wave_valid_q;

    logic [PHASE_W-1:0]       tri_t;
    logic [DATA_W-1:0]        raw;
    logic signed [DATA_W:0]   diff;
    logic signed [AMP_W+1:0]  gain;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        scaled;

    always_comb begin
        // Fold the upper half of the phase to get a symmetric triangle.
        tri_t = {p2_q[PHASE_W-2:0], 1'b0} ^ {PHASE_W{p2_q[PHASE_W-1]}};
        case (mode2_q)
            2'd0:    raw = rom_data;
            2'd1:    raw = p2_q[PHASE_W-1] ? '0 : '1;
            2'd2:    raw = DATA_W'(tri_t >> (PHASE_W - DATA_W));
            default: raw = DATA_W'(p2_q >> (PHASE_W - DATA_W));
        endcase
        diff   = $signed({1'b0, raw}) - $signed({1'b0, MID});
        gain   = $signed({2'b00, amp2_q} + (AMP_W + 2)'(1));
        prod   = PROD_W'(diff) * PROD_W'(gain);
        // |diff*gain| >> AMP_W never exceeds half scale, so keeping the
        // low DATA_W bits of the shifted product and adding midscale
        // cannot overflow.
        scaled = DATA_W'(prod >>> AMP_W);
        wave_out_d = MID + scaled;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q   <= '0;
            mode1_q      <= 2'd0;
            amp1_q       <= '1;
            vld1_q       <= 1'b0;
            p2_q         <= '0;
            mode2_q      <= 2'd0;
            amp2_q       <= '1;
            vld2_q       <= 1'b0;
            wave_out_q   <= '0;
            wave_valid_q <= 1'b0;
        end else begin
            rom_addr_q   <= phase_code;
            mode1_q      <= mode_q;
            amp1_q       <= amp_q;
            vld1_q       <= en;
            p2_q         <= rom_addr_q;
            mode2_q      <= mode1_q;
            amp2_q       <= amp1_q;
            vld2_q       <= vld1_q;
            wave_out_q   <= wave_out_d;
            wave_valid_q <= vld2_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign wave_out   = wave_out_q;
    assign wave_valid = wave_valid_q;
    assign sync_out   = sync_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_wave_gen
//
// Directed bench for dds_wave_gen. A reference model of the accumulator,
// config handshake and waveform formulas pushes the expected sample of each
// cycle into a scoreboard queue; the entry is popped and compared when the
// DUT presents it three clocks later. ROM address, sync pulse and cfg_ready
// are compared every cycle against the model.
// -----------------------------------------------------------------------------
module tb_dds_wave_gen;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 11;
    localparam int DATA_W  = 10;
    localparam int AMP_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               acc_clr;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [ACC_W-1:0]   cfg_freq;
    logic [PHASE_W-1:0] cfg_phase;
    logic [1:0]         cfg_wave;
    logic [AMP_W-1:0]   cfg_amp;
`ifdef DDS_SWEEP_EN
    logic [ACC_W-1:0]   sweep_step;
    logic [ACC_W-1:0]   sweep_stop;
`endif
    logic [PHASE_W-1:0] rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic [DATA_W-1:0]  wave_out;
    logic               wave_valid;
    logic               sync_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dds_wave_gen #(
        .ACC_W  (ACC_W),
        .PHASE_W(PHASE_W),
        .DATA_W (DATA_W),
        .AMP_W  (AMP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .acc_clr   (acc_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_freq  (cfg_freq),
        .cfg_phase (cfg_phase),
        .cfg_wave  (cfg_wave),
        .cfg_amp   (cfg_amp),
`ifdef DDS_SWEEP_EN
        .sweep_step(sweep_step),
        .sweep_stop(sweep_stop),
`endif
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wave_out  (wave_out),
        .wave_valid(wave_valid),
        .sync_out  (sync_out)
    );

    // Synchronous "sine" ROM with arbitrary but known contents.
    logic [DATA_W-1:0] rom_mem [0:(1<<PHASE_W)-1];
    initial begin
        for (int i = 0; i < (1 << PHASE_W); i++) begin
            rom_mem[i] = DATA_W'((i * 37 + 11) % 1024);
        end
    end
    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Reference model state
    logic [ACC_W-1:0]   m_acc, m_freq, m_base, s_freq;
    logic [PHASE_W-1:0] m_phase, s_phase;
    logic [1:0]         m_wave, s_wave;
    logic [AMP_W-1:0]   m_amp, s_amp;
    logic               m_pend, m_clrf;

    typedef logic [DATA_W:0] exp_t;   // {valid, sample}
    exp_t q_wave[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_sample(input logic [1:0] w,
                                                       input logic [AMP_W-1:0] a,
                                                       input logic [PHASE_W-1:0] p);
        int raw, pos, d, sc;
        pos = int'(p) % 1024;
        case (w)
            2'd0:    raw = int'(rom_mem[p]);
            2'd1:    raw = (int'(p) < 1024) ? 1023 : 0;
            2'd2:    raw = p[PHASE_W-1] ? (1023 - pos) : pos;
            default: raw = int'(p) / 2;
        endcase
        d  = raw - 512;
        sc = (d * (int'(a) + 1)) >>> AMP_W;
        return DATA_W'(512 + sc);
    endfunction

    task automatic model_reset();
        m_acc = '0; m_freq = '0; m_base = '0; m_phase = '0; m_wave = 2'd0; m_amp = '1;
        m_pend = 1'b0; m_clrf = 1'b0;
        s_freq = '0; s_phase = '0; s_wave = 2'd0; s_amp = '1;
        q_wave.delete();
    endtask

    // One clock: model the cycle, let the edge happen, compare.
    task automatic tick();
        logic [ACC_W:0]     s;
        logic [PHASE_W-1:0] p;
        logic               wrap, accept, apply;
        exp_t               e;
`ifdef DDS_SWEEP_EN
        logic [ACC_W:0]     ns;
`endif
        p = m_acc[ACC_W-1 -: PHASE_W] + m_phase;
        q_wave.push_back({en, model_sample(m_wave, m_amp, p)});
        s      = {1'b0, m_acc} + {1'b0, m_freq};
        wrap   = en && !acc_clr && s[ACC_W];
        accept = cfg_valid && !m_pend;
        apply  = m_pend && (!en || (m_freq == '0) || acc_clr || m_clrf || wrap);
        if (acc_clr)  m_acc = '0;
        else if (en)  m_acc = s[ACC_W-1:0];
        if (apply) begin
            m_freq = s_freq; m_phase = s_phase; m_wave = s_wave; m_amp = s_amp;
            m_base = s_freq; m_pend = 1'b0; m_clrf = 1'b0;
        end
`ifdef DDS_SWEEP_EN
        else if (wrap && (sweep_step != '0)) begin
            ns = {1'b0, m_freq} + {1'b0, sweep_step};
            m_freq = (ns >= {1'b0, sweep_stop}) ? m_base : ns[ACC_W-1:0];
        end
`endif
        if (accept) begin
            s_freq = cfg_freq; s_phase = cfg_phase; s_wave = cfg_wave; s_amp = cfg_amp;
            m_clrf = acc_clr; m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(p));
        chk("sync_out", 32'(sync_out), 32'(wrap));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        if (q_wave.size() == 3) begin
            e = q_wave.pop_front();
            chk("wave_valid", 32'(wave_valid), 32'(e[DATA_W]));
            if (e[DATA_W]) chk("wave_out", 32'(wave_out), 32'(e[DATA_W-1:0]));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cfg(input logic [ACC_W-1:0] f, input logic [PHASE_W-1:0] ph,
                            input logic [1:0] w, input logic [AMP_W-1:0] a);
        logic done;
        done = 1'b0;
        cfg_freq = f; cfg_phase = ph; cfg_wave = w; cfg_amp = a; cfg_valid = 1'b1;
        for (int i = 0; i < 10000 && !done; i++) begin
            done = !m_pend;
            tick();
        end
        cfg_valid = 1'b0;
        chk("cfg_accept_in_time", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
        chk({tag, "_wave_out"},   32'(wave_out),   32'd0);
        chk({tag, "_wave_valid"}, 32'(wave_valid), 32'd0);
        chk({tag, "_sync_out"},   32'(sync_out),   32'd0);
        chk({tag, "_cfg_ready"},  32'(cfg_ready),  32'd1);
    endtask

    initial begin
        int sync_cnt;
        rst_n = 1'b0; en = 1'b0; acc_clr = 1'b0; cfg_valid = 1'b0;
        cfg_freq = '0; cfg_phase = '0; cfg_wave = 2'd0; cfg_amp = '0;
`ifdef DDS_SWEEP_EN
        sweep_step = '0; sweep_stop = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sawtooth, K=2^21: address counts one per clock, sync every 2048
        send_cfg(32'h0020_0000, 11'd0, 2'd3, 8'hFF);
        en = 1'b1;
        sync_cnt = 0;
        for (int i = 0; i < 4200; i++) begin
            tick();
            sync_cnt += int'(sync_out);
        end
        chk("saw_sync_count", 32'(sync_cnt), 32'd2);

        // Square, K=2^28, full amplitude then amp=127
        send_cfg(32'h1000_0000, 11'd0, 2'd1, 8'd255);
        run(40);
        send_cfg(32'h1000_0000, 11'd0, 2'd1, 8'd127);
        run(40);

        // Mid-period retune to K=2^27 (waits for the wrap)
        run(5);
        send_cfg(32'h0800_0000, 11'd0, 2'd1, 8'd127);
        run(80);

        // Sawtooth with phase offset 1024
        send_cfg(32'h0020_0000, 11'd1024, 2'd3, 8'hFF);
        run(2100);

        // Triangle and sine with various amplitudes
        send_cfg(32'h0100_0000, 11'd5, 2'd2, 8'd200);
        run(300);
        send_cfg(32'h0100_0000, 11'd0, 2'd0, 8'hFF);
        run(300);
        send_cfg(32'h0100_0000, 11'd3, 2'd0, 8'd0);
        run(100);

        // Pending config forced in by acc_clr; then a stopped generator
        send_cfg(32'h0010_0000, 11'd0, 2'd2, 8'd90);
        run(2);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        run(20);
        en = 1'b0;
        send_cfg(32'h0400_0000, 11'd7, 2'd3, 8'd64);
        run(6);
        en = 1'b1;
        run(40);

        // Reset mid-run with a pending config
        send_cfg(32'h0200_0000, 11'd0, 2'd1, 8'hFF);
        chk("pending_before_reset", 32'(cfg_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(10);
        send_cfg(32'h0800_0000, 11'd0, 2'd3, 8'hFF);
        run(60);

`ifdef DDS_SWEEP_EN
        // Chirp: K=2^26 stepping by 2^26 up to 2^28
        sweep_step = 32'h0400_0000;
        sweep_stop = 32'h1000_0000;
        send_cfg(32'h0400_0000, 11'd0, 2'd3, 8'hFF);
        run(400);
        sweep_step = '0;
        run(80);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
Parametrised multi-waveform DDS generator, the next generation of the single-ROM sine DDS. It keeps a phase accumulator and adds a phase offset. It selects sine (external synchronous ROM), square, triangle or sawtooth output, applies amplitude scaling about midscale, and accepts configuration through a valid/ready handshake. A new configuration takes effect phase-continuously at the accumulator wrap.

Parameters:
ACC_W, 32, phase accumulator / frequency tuning word width
PHASE_W, 11, phase code width (ROM address width); must be >= DATA_W
DATA_W, 10, output sample width, unsigned offset-binary
AMP_W, 8, amplitude control width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  1 = accumulator advances; 0 = accumulator frozen
acc_clr  in  1  synchronous clear of accumulator; applies any pending config immediately
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free
cfg_freq  in  ACC_W  frequency tuning word K
cfg_phase  in  PHASE_W  phase offset P
cfg_wave  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
cfg_amp  in  AMP_W  amplitude; gain = (amp+1)/2^AMP_W
rom_addr  out  PHASE_W  sine ROM address (registered)
rom_data  in  DATA_W  sine ROM data, valid 1 clk after rom_addr
wave_out  out  DATA_W  output sample (registered)
wave_valid  out  1  wave_out carries a sample from an enabled cycle
sync_out  out  1  one-cycle pulse, registered, on accumulator carry-out

Behaviour:
- Reset values:
  - acc = 0.
  - Active config: freq 0, phase 0, wave sine, amp all-ones.
  - pending = 0; cfg_ready = 1.
  - rom_addr = 0; wave_out = 0; wave_valid = 0; sync_out = 0.
- Reset asserted mid-operation clears everything above, including any pending config.
- Accumulator: when en=1, acc <= acc + freq, modulo 2^ACC_W. Carry-out = wrap, and sets sync_out for the next cycle. When en=0, acc holds.
- acc_clr has priority over increment: acc <= 0, no sync pulse.
- Phase code p = acc[ACC_W-1 -: PHASE_W] + phase, modulo 2^PHASE_W (wrap, no saturation).
- Pipeline, with p computed in cycle n:
  - n+1: rom_addr = p; mode and amp are delayed alongside.
  - n+2: rom_data is valid.
  - n+3: wave_out is updated.
  - Latency is 3 clocks from acc to wave_out. wave_valid = en delayed 3 clocks.
  - Mode/amp changes align with the sample they apply to; no mixing within a sample.
- Raw sample by mode:
  - Sine: rom_data.
  - Sawtooth: p[PHASE_W-1 -: DATA_W].
  - Square: all-ones if p MSB = 0, else 0.
  - Triangle: t = {p[PHASE_W-2:0],1'b0}; if p MSB = 1 then t = ~t; sample = t[PHASE_W-1 -: DATA_W].
- Scaling: mid = 2^(DATA_W-1); d = raw - mid (signed); out = mid + ((d*(amp+1)) >>> AMP_W).
  - With amp all-ones, out = raw exactly.
  - The result never overflows DATA_W.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready; the words are captured into a shadow register and pending is set.
  - cfg_ready = !pending.
  - Shadow is applied to active config on the first wrap edge strictly after the acceptance cycle, and pending clears.
  - Immediate apply (next edge after acceptance) when any of:
    - en = 0;
    - active freq = 0;
    - acc_clr = 1, either in the acceptance cycle or while pending.
  - The accumulator value is never altered by a config apply, so freq changes are phase-continuous.
- cfg_valid while cfg_ready = 0: ignored; the source must hold its data.

Optional Feature:
DDS_SWEEP_EN:
- Adds ports sweep_step in ACC_W and sweep_stop in ACC_W.
- At each wrap, if sweep_step != 0:
  - freq <= freq + sweep_step;
  - when the new value would be >= sweep_stop, freq reloads the last applied cfg_freq instead (sawtooth chirp).
- A pending config apply on the same wrap wins over the sweep step.
- Without the macro: the ports are absent and freq changes only via config.

Test Plan:
- Reset, then config K=2^21, P=0, wave=3 (sawtooth), en=1 -> rom_addr counts 0,1,2,... per clk; sync_out pulses every 2048 clks; wave_out = rom_addr>>1 three clks later.
- K=2^28, wave=1 (square), amp=255 -> 16-clk period: 8 samples 1023, 8 samples 0.
- Same run, amp=127 -> high 767, low 256.
- Reconfigure mid-period with K=2^27 -> cfg_ready low until next sync_out; period becomes 32 clks with no phase jump at switch.
- P=1024 on sawtooth with K=2^21 -> rom_addr sequence offset by 1024, wraps 2047 -> 0.
- Assert rst_n low mid-run with a config pending -> all outputs 0, cfg_ready 1, pending dropped; after release, acc restarts from 0.
- DDS_SWEEP_EN, K=2^26, step=2^26, stop=2^28 -> periods 64, 32, 21/22, then back to 64.
